// File: rtl/i2c_burst_master.sv
// I2C burst master: START, address byte, up to 2^LEN_W-1 data bytes, STOP.
// Each SCL bit is four quarters of PRESCALE clk; SCL is stretched low while waiting for write data.
//
// state      | meaning
// IDLE       | bus released, waiting for start
// START      | SDA low with SCL high, then SCL low
// ADDR       | shifting {addr,rw}
// ADDR_ACK   | sampling slave ACK for address
// WAIT_WR    | SCL held low until a write byte arrives
// WRITE      | shifting write byte
// WRITE_ACK  | sampling slave ACK for data
// READ       | shifting in a byte from the slave
// READ_ACK   | master ACK (more bytes) or NACK (last byte)
// STOP       | SDA low, SCL high, then SDA high
module i2c_burst_master #(
  parameter int PRESCALE = 2,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [3:0]       state,
  output logic             sclk,
  input  logic             sda_in,
  output logic             sda_out
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LOAD = PW'(PRESCALE - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, START = 4'd1, ADDR = 4'd2, ADDR_ACK = 4'd3, WAIT_WR = 4'd4,
    WRITE = 4'd5, WRITE_ACK = 4'd6, READ = 4'd7, READ_ACK = 4'd8, STOP = 4'd9
  } state_t;

  state_t           st;
  logic [PW-1:0]    pcnt;
  logic [1:0]       q;
  logic [2:0]       bcnt;
  logic [7:0]       sh;
  logic [LEN_W-1:0] cnt;
  logic             rw_q;

  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= IDLE;
      pcnt     <= '0;
      q        <= 2'd0;
      bcnt     <= 3'd0;
      sh       <= 8'd0;
      cnt      <= '0;
      rw_q     <= 1'b0;
      sclk     <= 1'b1;
      sda_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            rw_q    <= rw;
            cnt     <= len;
            sh      <= {addr, rw};
            nack    <= 1'b0;
            busy    <= 1'b1;
            sda_out <= 1'b0;
            pcnt    <= P_LOAD;
            q       <= 2'd0;
            st      <= START;
          end
        end
        START, STOP: begin
          if (pcnt != '0) pcnt <= pcnt - PW'(1);
          else begin
            pcnt <= P_LOAD;
            q    <= q + 2'd1;
            if (st == START) begin
              if (q == 2'd0) sclk <= 1'b0;
              else begin
                // SCL has been low a full quarter before the first data bit moves SDA
                st      <= ADDR;
                q       <= 2'd0;
                bcnt    <= 3'd7;
                sda_out <= sh[7];
              end
            end else begin
              if (q == 2'd0) sclk <= 1'b1;
              else if (q == 2'd1) sda_out <= 1'b1;
              else begin
                st   <= IDLE;
                q    <= 2'd0;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end
        end
        WAIT_WR: begin
          if (wr_valid && wr_ready) begin
            sh       <= wr_data;
            sda_out  <= wr_data[7];
            wr_ready <= 1'b0;
            bcnt     <= 3'd7;
            pcnt     <= P_LOAD;
            q        <= 2'd0;
            st       <= WRITE;
          end
        end
        ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK: begin
          if (pcnt != '0) pcnt <= pcnt - PW'(1);
          else begin
            pcnt <= P_LOAD;
            q    <= q + 2'd1;
            if (q == 2'd0) sclk <= 1'b1;
            if (q == 2'd2) begin
              // one shifter serves transmit and receive; sh[0] holds the latest sample
              sclk <= 1'b0;
              sh   <= {sh[6:0], sda_in};
              if (st == READ && bcnt == 3'd0) begin
                rd_data  <= {sh[6:0], sda_in};
                rd_valid <= 1'b1;
                if (cnt != '0) cnt <= cnt - LEN_W'(1);
              end
            end
            if (q == 2'd3) begin
              case (st)
                ADDR, WRITE: begin
                  if (bcnt == 3'd0) begin
                    st      <= (st == ADDR) ? ADDR_ACK : WRITE_ACK;
                    sda_out <= 1'b1;
                    if (st == WRITE && cnt != '0) cnt <= cnt - LEN_W'(1);
                  end else begin
                    bcnt    <= bcnt - 3'd1;
                    sda_out <= sh[7];
                  end
                end
                READ: begin
                  if (bcnt == 3'd0) begin
                    st      <= READ_ACK;
                    sda_out <= (cnt == '0);
                  end else bcnt <= bcnt - 3'd1;
                end
                ADDR_ACK, WRITE_ACK: begin
                  if (sh[0]) begin
                    nack    <= 1'b1;
                    sda_out <= 1'b0;
                    st      <= STOP;
                  end else if (cnt == '0) begin
                    sda_out <= 1'b0;
                    st      <= STOP;
                  end else if (st == ADDR_ACK && rw_q) begin
                    bcnt    <= 3'd7;
                    sda_out <= 1'b1;
                    st      <= READ;
                  end else begin
                    wr_ready <= 1'b1;
                    st       <= WAIT_WR;
                  end
                end
                READ_ACK: begin
                  if (cnt == '0) begin
                    sda_out <= 1'b0;
                    st      <= STOP;
                  end else begin
                    bcnt    <= 3'd7;
                    sda_out <= 1'b1;
                    st      <= READ;
                  end
                end
                default: st <= IDLE;
              endcase
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_burst_master.sv
// Directed bench for i2c_burst_master: a behavioural slave decodes the bus into a log of
// START / {ack,byte} / STOP events that is compared against a table of transactions.
module tb_i2c_burst_master;
  logic       clk = 1'b0;
  logic       rst, start, rw, wr_valid, sda_in;
  logic [6:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data, rd_data;
  logic       wr_ready, rd_valid, busy, done, nack, sclk, sda_out;
  logic [3:0] state;

  always #5 clk = ~clk;

  i2c_burst_master #(.PRESCALE(2), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
    .state(state), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out)
  );

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [3:0]  len;
    logic [31:0] data;       // byte i at [8*i +: 8]
    logic        nack_addr;  // slave NACKs the address
    int          nack_byte;  // slave NACKs this data byte (1-based), 0 = never
    int          stall;      // clk cycles wr_valid is held low on the first WAIT_WR
    logic        exp_nack;
    int          exp_hs;
    int          exp_rdv;
  } txn_t;

  txn_t tbl[7];

  int checks = 0;
  int errors = 0;

  // slave model state
  logic        sl_drive = 1'b1;
  logic [31:0] sl_rd = '0;
  logic        sl_nack_addr = 1'b0;
  int          sl_nack_byte = 0;
  logic        sl_active = 1'b0, sl_read = 1'b0, sl_rdstop = 1'b0;
  int          sl_bitn = 0, sl_byten = 0;
  logic [8:0]  sl_sh = '0;
  logic        p_scl = 1'b1, p_line = 1'b1;
  logic [9:0]  bus_log[$];

  int          hs_cnt = 0, done_cnt = 0, wr_seen = 0;
  logic [7:0]  rd_q[$];

  assign sda_in = sda_out & sl_drive;

  always @(negedge clk) begin
    if (!rst) begin
      sl_drive  = 1'b1;
      sl_active = 1'b0;
      sl_bitn   = 0;
      sl_byten  = 0;
    end else if (p_scl && sclk && p_line && !sda_in) begin
      bus_log.push_back(10'h200);
      sl_active = 1'b1; sl_bitn = 0; sl_byten = 0; sl_read = 1'b0; sl_rdstop = 1'b0;
    end else if (p_scl && sclk && !p_line && sda_in) begin
      bus_log.push_back(10'h300);
      sl_active = 1'b0;
    end else if (sl_active && !p_scl && sclk) begin
      sl_sh = {sl_sh[7:0], sda_in};
      sl_bitn++;
      if (sl_bitn == 9) begin
        bus_log.push_back({1'b0, sl_sh[0], sl_sh[8:1]});
        if (sl_byten == 0) sl_read = sl_sh[1];
        else if (sl_read && sl_sh[0]) sl_rdstop = 1'b1;
        sl_byten++;
        sl_bitn = 0;
      end
    end else if (sl_active && p_scl && !sclk) begin
      if (sl_bitn == 8) begin
        if (sl_byten == 0) sl_drive = sl_nack_addr;
        else if (!sl_read) sl_drive = (sl_nack_byte == sl_byten);
        else sl_drive = 1'b1;
      end else if (sl_read && sl_byten > 0 && sl_byten <= 4 && !sl_rdstop)
        sl_drive = sl_rd[8*(sl_byten-1) + 7 - sl_bitn];
      else
        sl_drive = 1'b1;
    end
    p_scl  = sclk;
    p_line = sda_in;
  end

  always @(posedge clk) if (rst && wr_valid && wr_ready) hs_cnt++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wr_ready) wr_seen++;
    if (rd_valid) rd_q.push_back(rd_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    logic [9:0] exp[$];
    int fed, stall_left, cyc, sclk_err;
    bit got_done;
    sl_rd = t.data; sl_nack_addr = t.nack_addr; sl_nack_byte = t.nack_byte;
    bus_log.delete(); rd_q.delete();
    hs_cnt = 0; done_cnt = 0; wr_seen = 0;

    exp.push_back(10'h200);
    exp.push_back({1'b0, t.nack_addr, t.addr, t.rw});
    if (!t.nack_addr)
      for (int i = 0; i < int'(t.len); i++) begin
        if (t.rw) exp.push_back({1'b0, (i == int'(t.len) - 1), t.data[8*i +: 8]});
        else begin
          exp.push_back({1'b0, (t.nack_byte == i + 1), t.data[8*i +: 8]});
          if (t.nack_byte == i + 1) break;
        end
      end
    exp.push_back(10'h300);

    @(negedge clk);
    start = 1'b1; rw = t.rw; addr = t.addr; len = t.len;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("t%0d busy_after_start", idx), busy, 1);
    chk($sformatf("t%0d state_start", idx), state, 1);
    chk($sformatf("t%0d nack_cleared", idx), nack, 0);

    fed = 0; stall_left = t.stall; cyc = 0; got_done = 0; sclk_err = 0;
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1;
        chk($sformatf("t%0d busy_at_done", idx), busy, 0);
        chk($sformatf("t%0d idle_at_done", idx), state, 0);
      end else if (wr_valid) begin
        wr_valid = 1'b0;
        fed++;
      end else if (wr_ready && fed < int'(t.len)) begin
        if (stall_left > 0) begin
          stall_left--;
          if (sclk !== 1'b0) sclk_err++;
        end else begin
          wr_data  = t.data[8*fed +: 8];
          wr_valid = 1'b1;
        end
      end
    end
    chk($sformatf("t%0d done_seen", idx), got_done, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("t%0d done_once", idx), done_cnt, 1);
    chk($sformatf("t%0d nack", idx), nack, t.exp_nack);
    chk($sformatf("t%0d wr_handshakes", idx), hs_cnt, t.exp_hs);
    if (t.exp_hs == 0) chk($sformatf("t%0d wr_ready_never", idx), wr_seen, 0);
    chk($sformatf("t%0d rd_pulses", idx), rd_q.size(), t.exp_rdv);
    for (int i = 0; i < rd_q.size() && i < 4; i++)
      chk($sformatf("t%0d rd_data[%0d]", idx, i), rd_q[i], t.data[8*i +: 8]);
    if (t.stall > 0) chk($sformatf("t%0d stretch_scl", idx), sclk_err, 0);
    chk($sformatf("t%0d log_len", idx), bus_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++)
      chk($sformatf("t%0d bus[%0d]", idx, i), bus_log[i], exp[i]);
    chk($sformatf("t%0d idle_lines", idx), {sclk, sda_out}, 2'b11);
  endtask

  initial begin
    int cyc, nstop;
    rst = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; len = '0; wr_data = '0; wr_valid = 1'b0;

    //           rw    addr   len   data          nack_a nb stall exp_nack hs rdv
    tbl[0] = '{1'b0, 7'h50, 4'd2, 32'h0000_3CA6, 1'b0, 0, 0,  1'b0, 2, 0};
    tbl[1] = '{1'b1, 7'h50, 4'd3, 32'h0080_12F6, 1'b0, 0, 0,  1'b0, 0, 3};
    tbl[2] = '{1'b0, 7'h50, 4'd2, 32'h0000_3CA6, 1'b1, 0, 0,  1'b1, 0, 0};
    tbl[3] = '{1'b0, 7'h50, 4'd2, 32'h0000_8011, 1'b0, 0, 20, 1'b0, 2, 0};
    tbl[4] = '{1'b0, 7'h3C, 4'd0, 32'h0000_0000, 1'b0, 0, 0,  1'b0, 0, 0};
    tbl[5] = '{1'b0, 7'h22, 4'd3, 32'h0000_C35A, 1'b0, 1, 0,  1'b1, 1, 0};
    tbl[6] = '{1'b1, 7'h7F, 4'd1, 32'h0000_0001, 1'b0, 0, 0,  1'b0, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst sclk", sclk, 1);
    chk("rst sda_out", sda_out, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst nack", nack, 0);
    chk("rst wr_ready", wr_ready, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst state", state, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_txn(tbl[k], k);

    // reset in the middle of a read byte
    bus_log.delete();
    sl_rd = 32'h0000_12F6; sl_nack_addr = 1'b0; sl_nack_byte = 0;
    @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h50; len = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(state == 4'd7 && sl_bitn == 4) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_read_bit4", (cyc < 2000), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst sclk", sclk, 1);
    chk("midrst sda_out", sda_out, 1);
    chk("midrst busy", busy, 0);
    chk("midrst state", state, 0);
    chk("midrst rd_data", rd_data, 0);
    chk("midrst rd_valid", rd_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    nstop = 0;
    foreach (bus_log[i]) if (bus_log[i] == 10'h300) nstop++;
    chk("midrst no_stop", nstop, 0);
    run_txn(tbl[1], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_burst_master.md
I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

Interface
REQ-001 SHALL have parameter PRESCALE, default 2: clk cycles per SCL quarter-period (>=1); SCL period = 4*PRESCALE clk.
REQ-002 SHALL have parameter LEN_W, default 4: width of the byte-count input; max burst = 2^LEN_W-1 bytes.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a transaction; sampled only in IDLE.
REQ-006 SHALL have port rw  input  1  1=read, 0=write; captured with start.
REQ-007 SHALL have port addr  input  7  slave address; captured with start.
REQ-008 SHALL have port len  input  LEN_W  bytes to transfer; captured with start; 0 = address-only probe.
REQ-009 SHALL have port wr_data  input  8  next write byte.
REQ-010 SHALL have port wr_valid  input  1  wr_data valid.
REQ-011 SHALL have port wr_ready  output  1  master can accept a write byte.
REQ-012 SHALL have port rd_data  output  8  last received byte.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 SHALL have port busy  output  1  high from start acceptance until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of transaction.
REQ-016 SHALL have port nack  output  1  sticky slave-NACK flag, cleared on next accepted start.
REQ-017 SHALL have port state  output  4  current FSM state code.
REQ-018 SHALL have port sclk  output  1  SCL, 1 = released/high.
REQ-019 SHALL have port sda_in  input  1  sampled SDA line.
REQ-020 SHALL have port sda_out  output  1  SDA drive, 1 = release, 0 = pull low.

Function
REQ-021 SHALL implement states IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WAIT_WR=4, WRITE=5, WRITE_ACK=6, READ=7, READ_ACK=8, STOP=9; no other codes reachable.
REQ-022 SHALL run each bit as 4 quarters of PRESCALE clk: Q0 SCL low, SDA updated; Q1 SCL high; Q2 SDA sampled at last clk of quarter; Q3 SCL low.
REQ-023 SHALL, in IDLE with start=1, capture rw/addr/len, clear nack, set busy next cycle, enter START; start ignored in all other states.
REQ-024 SHALL generate START as SDA 1->0 with SCL high, held PRESCALE clk, then SCL low; then ADDR.
REQ-025 SHALL shift address byte {addr,rw} MSB first, 8 bits, then ADDR_ACK (SDA released, sda_in sampled in Q2).
REQ-026 SHALL, on ADDR_ACK sda_in=1, set nack=1 and go to STOP; no wr_ready, no rd_valid.
REQ-027 SHALL, on ACK with len=0, go to STOP; with rw=0 go to WAIT_WR; with rw=1 go to READ.
REQ-028 SHALL, in WAIT_WR, assert wr_ready and hold SCL low (stretch) indefinitely; on wr_valid&wr_ready capture wr_data, deassert wr_ready next cycle, enter WRITE.
REQ-029 SHALL shift the write byte MSB first, then WRITE_ACK; ACK with bytes remaining -> WAIT_WR; ACK on last byte -> STOP; NACK -> nack=1, STOP (remaining bytes abandoned).
REQ-030 SHALL, in READ, release SDA and shift in 8 bits MSB first; update rd_data and pulse rd_valid the cycle after the 8th Q2 sample.
REQ-031 SHALL, in READ_ACK, drive SDA low (ACK) if bytes remain, release SDA (NACK) on the last byte; then READ or STOP.
REQ-032 SHALL generate STOP as SDA low with SCL low PRESCALE clk, SCL high PRESCALE clk, then SDA 1 with SCL high PRESCALE clk; then IDLE, pulse done, drop busy in the same cycle.
REQ-033 SHALL decrement an internal LEN_W-bit byte counter once per completed data byte; no wrap, transaction ends at 0.
REQ-034 SHALL change SDA only while SCL is low, except in START/STOP.

Reset
REQ-035 SHALL, on clk edge with rst=0 in any state (including mid-byte), go to IDLE: sclk=1, sda_out=1, busy=0, done=0, nack=0, wr_ready=0, rd_valid=0, rd_data=0, state=0, counters cleared; no STOP generated.

Verification
REQ-036 SHALL cover PRESCALE=2, write addr=0x50 len=2 data 0xA6,0x3C, slave ACKs -> SDA bytes 0xA0,0xA6,0x3C, two wr_ready handshakes, done=1 once, nack=0.
REQ-037 SHALL cover read addr=0x50 len=3, slave drives 0xF6,0x12,0x80 -> address byte 0xA1, three rd_valid pulses with those values, master ACK,ACK,NACK, STOP.
REQ-038 SHALL cover address NACK (sda_in=1 in ADDR_ACK) -> nack=1, STOP, done pulse, wr_ready never high.
REQ-039 SHALL cover write with wr_valid low 20 clk in WAIT_WR -> sclk held 0, no SCL edges, transfer resumes correctly after wr_valid=1.
REQ-040 SHALL cover rst=0 during READ bit 4 -> next cycle sclk=1, sda_out=1, busy=0, state=0; following start runs a clean transaction.
REQ-041 SHALL cover len=0 probe with ACK -> START, address byte, ACK, STOP only; done pulse, nack=0.
